// File: rtl/fp_normalizer.sv
// Post-adder normalizer: takes the raw {c_out,sum} mantissa, shifts it into
// normalized position, and packs an IEEE-754 single with zero/inf/flush handling.
module fp_normalizer #(
  parameter int unsigned MANT_W = 24,
  parameter int unsigned EXP_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      load,
  input  logic [MANT_W-1:0]         sum,
  input  logic                      c_out,
  input  logic                      signS,
  input  logic [EXP_W-1:0]          exp_in,
  output logic [EXP_W+MANT_W-1:0]   result,
  output logic                      done,
  output logic                      busy,
  output logic                      zero,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int unsigned XEXP_W  = EXP_W + 1;
  localparam int unsigned RAW_W   = MANT_W + 1;
  localparam int unsigned FRAC_W  = MANT_W - 1;
  localparam int unsigned RES_W   = EXP_W + MANT_W;
  localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHECK   = 3'd1;
  localparam logic [2:0] S_SHIFT_R = 3'd2;
  localparam logic [2:0] S_SHIFT_L = 3'd3;
  localparam logic [2:0] S_PACK    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]        state, state_n;
  logic [RAW_W-1:0]  mant, mant_n;
  logic [XEXP_W-1:0] exp_r, exp_n;
  logic              sign, sign_n;
  logic [RES_W-1:0]  result_n;
  logic              done_n, busy_n, zero_n, overflow_n, underflow_n;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      mant      <= '0;
      exp_r     <= '0;
      sign      <= 1'b0;
      result    <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_n;
      mant      <= mant_n;
      exp_r     <= exp_n;
      sign      <= sign_n;
      result    <= result_n;
      done      <= done_n;
      busy      <= busy_n;
      zero      <= zero_n;
      overflow  <= overflow_n;
      underflow <= underflow_n;
    end
  end

  // Next-state and next-output logic; en=0 holds everything
  always_comb begin
    state_n     = state;
    mant_n      = mant;
    exp_n       = exp_r;
    sign_n      = sign;
    result_n    = result;
    done_n      = done;
    busy_n      = busy;
    zero_n      = zero;
    overflow_n  = overflow;
    underflow_n = underflow;
    if (en) begin
      case (state)
        S_IDLE, S_DONE: begin
          done_n = 1'b0;
          if (load) begin
            mant_n      = {c_out, sum};
            exp_n       = {1'b0, exp_in};
            sign_n      = signS;
            zero_n      = 1'b0;
            overflow_n  = 1'b0;
            underflow_n = 1'b0;
            busy_n      = 1'b1;
            state_n     = S_CHECK;
          end else begin
            busy_n  = 1'b0;
            state_n = S_IDLE;
          end
        end
        S_CHECK: begin
          if (mant[MANT_W]) begin
            state_n = S_SHIFT_R;
          end else if (mant == '0) begin
            zero_n  = 1'b1;
            sign_n  = 1'b0;
            state_n = S_PACK;
          end else if (mant[MANT_W-1]) begin
            state_n = S_PACK;
          end else begin
            state_n = S_SHIFT_L;
          end
        end
        S_SHIFT_R: begin
          mant_n = {1'b0, 1'b1, mant[MANT_W-1:1]};
          // 9-bit exponent lets the 254->255 step be caught before it wraps
          if (exp_r >= XEXP_W'(EXP_MAX - 1)) begin
            overflow_n = 1'b1;
            exp_n      = XEXP_W'(EXP_MAX);
          end else begin
            exp_n = exp_r + XEXP_W'(1);
          end
          state_n = S_PACK;
        end
        S_SHIFT_L: begin
          if (exp_r <= XEXP_W'(1)) begin
            underflow_n = 1'b1;
            state_n     = S_PACK;
          end else begin
            mant_n = {mant[MANT_W-1:0], 1'b0};
            exp_n  = exp_r - XEXP_W'(1);
            if (mant[MANT_W-2]) state_n = S_PACK;
          end
        end
        S_PACK: begin
          if (zero || underflow) begin
            result_n = '0;
          end else if (overflow) begin
            result_n = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          end else begin
            result_n = {sign, exp_r[EXP_W-1:0], mant[FRAC_W-1:0]};
          end
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = S_DONE;
        end
        default: begin
          busy_n  = 1'b0;
          done_n  = 1'b0;
          state_n = S_IDLE;
        end
      endcase
    end
  end

endmodule
